// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared size encodings, FSM states and widths for the memory access stage
package mem_access_stage_pkg;
  localparam int PC_W = 32;
  localparam int SIZE_W = 2;
  localparam int ST_W = 2;
  localparam logic [SIZE_W-1:0] SZ_B = 2'd0;
  localparam logic [SIZE_W-1:0] SZ_H = 2'd1;
  localparam logic [SIZE_W-1:0] SZ_W = 2'd2;
  localparam logic [SIZE_W-1:0] SZ_D = 2'd3;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_REQ = 2'd1;
  localparam logic [ST_W-1:0] ST_WAIT = 2'd2;
  // doubleword accesses do not exist on a 32-bit datapath
  function automatic logic is_aligned(input logic [2:0] a, input logic [SIZE_W-1:0] s, input int xlen);
    logic [2:0] m;
    m = (3'b001 << s) - 3'b001;
    return (a & m) == 3'b000 && !(xlen == 32 && s == SZ_D);
  endfunction
endpackage

// File: rtl/mem_access_stage_lane.sv
// mem_lane_align: store byte-enable/lane replication and load lane extract with sign/zero extend
module mem_lane_align
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [SIZE_W-1:0]          size,
  input  logic                       is_unsigned,
  input  logic [$clog2(XLEN/8)-1:0]  off,
  input  logic [XLEN-1:0]            wdata,
  input  logic [XLEN-1:0]            rdata,
  output logic [XLEN/8-1:0]          be,
  output logic [XLEN-1:0]            wdata_lanes,
  output logic [XLEN-1:0]            rdata_ext
);
  localparam int BW = XLEN / 8;
  logic [BW-1:0] m;
  logic [XLEN-1:0] rd, up;
  logic signed [XLEN-1:0] sx;
  logic [6:0] sh;
  assign m = size == SZ_B ? BW'(1) : size == SZ_H ? BW'(3) : size == SZ_W ? BW'(15) : '1;
  assign be = m << off;
  assign wdata_lanes = size == SZ_B ? {BW{wdata[7:0]}} :
                       size == SZ_H ? {(XLEN/16){wdata[15:0]}} :
                       size == SZ_W ? {(XLEN/32){wdata[31:0]}} : wdata;
  // park the selected lane at the top, then shift back down to extend
  assign rd = rdata >> {off, 3'b000};
  assign sh = 7'(XLEN) - (7'd8 << size);
  assign up = rd << sh;
  assign sx = $signed(up) >>> sh;
  assign rdata_ext = is_unsigned ? up >> sh : sx;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline memory stage with req/gnt/rvalid handshake, timeout and misalign detection
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RF_AW = 5,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [PC_W-1:0]     in_pc,
  input  logic                in_mem_en,
  input  logic                in_mem_we,
  input  logic [SIZE_W-1:0]   in_size,
  input  logic                in_unsigned,
  input  logic [XLEN-1:0]     in_addr,
  input  logic [XLEN-1:0]     in_wdata,
  input  logic                in_rf_we,
  input  logic [RF_AW-1:0]    in_rf_waddr,
  input  logic [XLEN-1:0]     in_ex_result,
  output logic                mem_req,
  output logic                mem_we,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                stall_req,
  output logic                wb_valid,
  output logic [PC_W-1:0]     wb_pc,
  output logic                wb_rf_we,
  output logic [RF_AW-1:0]    wb_rf_waddr,
  output logic [XLEN-1:0]     wb_rf_wdata,
  output logic                fwd_we,
  output logic [RF_AW-1:0]    fwd_waddr,
  output logic [XLEN-1:0]     fwd_wdata,
  output logic                fwd_pending,
  output logic                misalign_exc,
  output logic                timeout_err
);
  localparam int BW = XLEN / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  logic op_valid, op_mem_en, op_we, op_uns, op_rf_we;
  logic [PC_W-1:0] op_pc;
  logic [SIZE_W-1:0] op_size;
  logic [XLEN-1:0] op_addr, op_wdata, op_ex;
  logic [RF_AW-1:0] op_waddr;
  logic [ST_W-1:0] state, state_nx;
  logic [CW-1:0] cnt;
  logic v, aligned, is_load, done_now, timeout_now, capture;
  logic [XLEN-1:0] ld_data, lanes;
  logic [BW-1:0] be;
  mem_lane_align #(.XLEN(XLEN)) u_lane (
    .size(op_size), .is_unsigned(op_uns), .off(op_addr[$clog2(BW)-1:0]),
    .wdata(op_wdata), .rdata(mem_rdata), .be(be), .wdata_lanes(lanes), .rdata_ext(ld_data)
  );
  assign v = op_valid && !rst;
  assign aligned = !op_mem_en || is_aligned(op_addr[2:0], op_size, XLEN);
  assign is_load = op_mem_en && !op_we;
  assign timeout_now = v && state != ST_IDLE && cnt == CW'(TIMEOUT);
  assign done_now = v && ((state == ST_REQ && mem_gnt && op_we) || (state == ST_WAIT && mem_rvalid));
  assign stall_req = v && op_mem_en && aligned && !done_now && !timeout_now;
  assign capture = !hold && !stall_req;
  assign mem_req = v && state == ST_REQ && !timeout_now;
  assign mem_we = mem_req && op_we;
  assign mem_be = mem_req ? be : '0;
  assign mem_addr = mem_req ? op_addr : '0;
  assign mem_wdata = mem_we ? lanes : '0;
  assign wb_valid = v && (!op_mem_en || !aligned || done_now || timeout_now);
  assign wb_pc = v ? op_pc : '0;
  assign wb_rf_we = op_rf_we && wb_valid && aligned && !timeout_now;
  assign wb_rf_waddr = v ? op_waddr : '0;
  assign wb_rf_wdata = v ? (is_load ? ld_data : op_ex) : '0;
  assign fwd_we = wb_rf_we;
  assign fwd_waddr = wb_rf_waddr;
  assign fwd_wdata = wb_rf_wdata;
  assign fwd_pending = v && is_load && op_rf_we && !done_now;
  assign misalign_exc = v && !aligned;
  assign timeout_err = timeout_now;
  assign state_nx = timeout_now ? ST_IDLE :
                    state == ST_REQ ? (mem_gnt ? (op_we ? ST_IDLE : ST_WAIT) : ST_REQ) :
                    state == ST_WAIT ? (mem_rvalid ? ST_IDLE : ST_WAIT) : ST_IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid <= 1'b0;
      op_pc <= '0;
      op_mem_en <= 1'b0;
      op_we <= 1'b0;
      op_size <= '0;
      op_uns <= 1'b0;
      op_addr <= '0;
      op_wdata <= '0;
      op_rf_we <= 1'b0;
      op_waddr <= '0;
      op_ex <= '0;
      state <= ST_IDLE;
      cnt <= '0;
    end else if (capture) begin
      op_valid <= in_valid && !flush;
      op_pc <= in_pc;
      op_mem_en <= in_mem_en;
      op_we <= in_mem_we;
      op_size <= in_size;
      op_uns <= in_unsigned;
      op_addr <= in_addr;
      op_wdata <= in_wdata;
      op_rf_we <= in_rf_we;
      op_waddr <= in_rf_waddr;
      op_ex <= in_ex_result;
      state <= (in_valid && !flush && in_mem_en && is_aligned(in_addr[2:0], in_size, XLEN)) ? ST_REQ : ST_IDLE;
      cnt <= '0;
    end else begin
      // an op that retires while upstream holds must not re-issue or re-stall
      op_valid <= op_valid && !wb_valid;
      state <= state_nx;
      cnt <= state != ST_IDLE ? cnt + 1'b1 : cnt;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed vector table plus hand sequences for timeout, reset and flush
module tb_mem_access_stage;
  logic clk = 1'b0;
  logic rst, hold, flush, in_valid, in_mem_en, in_mem_we, in_unsigned, in_rf_we;
  logic [31:0] in_pc, in_addr, in_wdata, in_ex_result, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] wb_pc, wb_rf_wdata, fwd_wdata;
  logic [1:0] in_size;
  logic [4:0] in_rf_waddr, wb_rf_waddr, fwd_waddr;
  logic [3:0] mem_be;
  logic mem_req, mem_we, mem_gnt, mem_rvalid, stall_req, wb_valid, wb_rf_we;
  logic fwd_we, fwd_pending, misalign_exc, timeout_err;
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  mem_access_stage #(.XLEN(32), .RF_AW(5), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_mem_en(in_mem_en), .in_mem_we(in_mem_we), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
    .in_ex_result(in_ex_result), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .stall_req(stall_req), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata), .fwd_we(fwd_we),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_pending(fwd_pending),
    .misalign_exc(misalign_exc), .timeout_err(timeout_err)
  );
  typedef struct {
    logic we;
    logic [1:0] size;
    logic uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic mis;
    logic [3:0] be;
    logic [31:0] exp;
  } vec_t;
  vec_t tv[11];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic drive_op(input logic me, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ex);
    in_valid = 1'b1;
    in_pc = 32'h1000;
    in_mem_en = me;
    in_mem_we = we;
    in_size = sz;
    in_unsigned = uns;
    in_addr = a;
    in_wdata = wd;
    in_rf_we = !we;
    in_rf_waddr = 5'd7;
    in_ex_result = ex;
    nxt;
    in_valid = 1'b0;
    #1;
  endtask
  initial begin
    int st;
    rst = 1'b1; hold = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_mem_en = 1'b0;
    in_mem_we = 1'b0; in_size = '0; in_unsigned = 1'b0; in_addr = '0; in_wdata = '0;
    in_rf_we = 1'b0; in_rf_waddr = '0; in_ex_result = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0;
    tv[0]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 1'b0, 4'h0, 32'hFFFFFF80};
    tv[1]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 1'b0, 4'h0, 32'h00000080};
    tv[2]  = '{1'b1, 2'd1, 1'b0, 32'h102, 32'h1234, 32'h0, 1'b0, 4'b1100, 32'h12341234};
    tv[3]  = '{1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0};
    tv[4]  = '{1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 32'h12348001, 1'b0, 4'h0, 32'hFFFF8001};
    tv[5]  = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h80011234, 1'b0, 4'h0, 32'h00008001};
    tv[6]  = '{1'b1, 2'd0, 1'b0, 32'h101, 32'hAB, 32'h0, 1'b0, 4'b0010, 32'hABABABAB};
    tv[7]  = '{1'b1, 2'd2, 1'b0, 32'h104, 32'hCAFEF00D, 32'h0, 1'b0, 4'b1111, 32'hCAFEF00D};
    tv[8]  = '{1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0};
    tv[9]  = '{1'b0, 2'd1, 1'b0, 32'h103, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0};
    tv[10] = '{1'b0, 2'd0, 1'b0, 32'h102, 32'h0, 32'h0055AAAA, 1'b0, 4'h0, 32'h00000055};
    nxt;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 11; i++) begin
      drive_op(1'b1, tv[i].we, tv[i].size, tv[i].uns, tv[i].addr, tv[i].wdata, 32'h0);
      if (tv[i].mis) begin
        chk($sformatf("v%0d_mis_exc", i), misalign_exc, 1);
        chk($sformatf("v%0d_mis_req", i), mem_req, 0);
        chk($sformatf("v%0d_mis_stall", i), stall_req, 0);
        chk($sformatf("v%0d_mis_wb_rf_we", i), wb_rf_we, 0);
        nxt;
        chk($sformatf("v%0d_mis_pulse", i), misalign_exc, 0);
      end else begin
        chk($sformatf("v%0d_req", i), mem_req, 1);
        mem_gnt = 1'b1;
        #1;
        if (tv[i].we) begin
          chk($sformatf("v%0d_be", i), mem_be, tv[i].be);
          chk($sformatf("v%0d_wdata", i), mem_wdata, tv[i].exp);
          chk($sformatf("v%0d_st_done", i), wb_valid, 1);
          chk($sformatf("v%0d_st_rf_we", i), wb_rf_we, 0);
          chk($sformatf("v%0d_st_stall", i), stall_req, 0);
          nxt;
          mem_gnt = 1'b0;
          #1;
        end else begin
          nxt;
          mem_gnt = 1'b0;
          mem_rvalid = 1'b1;
          mem_rdata = tv[i].rdata;
          #1;
          chk($sformatf("v%0d_ld_data", i), wb_rf_wdata, tv[i].exp);
          chk($sformatf("v%0d_ld_rf_we", i), wb_rf_we, 1);
          chk($sformatf("v%0d_ld_stall", i), stall_req, 0);
          nxt;
          mem_rvalid = 1'b0;
          #1;
        end
      end
    end
    // lw 0x100: gnt on cycle 1, rvalid on cycle 3
    drive_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0);
    chk("lw_addr", mem_addr, 32'h100);
    st = 0;
    for (int c = 0; c < 4; c++) begin
      mem_gnt = (c == 1);
      mem_rvalid = (c == 3);
      mem_rdata = 32'hDEADBEEF;
      #1;
      st += int'(stall_req);
      if (c == 2) begin
        chk("lw_wait_req", mem_req, 0);
        chk("lw_fwd_pending", fwd_pending, 1);
      end
      if (c == 3) begin
        chk("lw_data", wb_rf_wdata, 32'hDEADBEEF);
        chk("lw_fwd_we", fwd_we, 1);
        chk("lw_fwd_wdata", fwd_wdata, 32'hDEADBEEF);
      end
      nxt;
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    chk("lw_stall_cycles", st, 3);
    #1;
    // no grant: timeout on the 5th cycle with TIMEOUT=4
    drive_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      if (c == 4) chk("to_early", timeout_err, 0);
      if (c == 5) begin
        chk("to_err", timeout_err, 1);
        chk("to_wb_valid", wb_valid, 1);
        chk("to_rf_we", wb_rf_we, 0);
        chk("to_stall", stall_req, 0);
      end
      if (c < 5) nxt;
    end
    nxt;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h1234;
    #1;
    chk("late_rvalid_wb", wb_valid, 0);
    chk("late_rvalid_fwd", fwd_we, 0);
    mem_rvalid = 1'b0;
    // reset while in REQ and while in WAIT
    drive_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0);
    chk("rreq_req", mem_req, 1);
    rst = 1'b1;
    #1;
    chk("rreq_drop", mem_req, 0);
    nxt;
    rst = 1'b0;
    #1;
    chk("rreq_after", mem_req, 0);
    drive_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0);
    mem_gnt = 1'b1;
    #1;
    nxt;
    mem_gnt = 1'b0;
    #1;
    chk("rwait_pending", fwd_pending, 1);
    rst = 1'b1;
    #1;
    chk("rwait_stall", stall_req, 0);
    chk("rwait_pending0", fwd_pending, 0);
    nxt;
    rst = 1'b0;
    mem_rvalid = 1'b1;
    #1;
    chk("rwait_idle_stall", stall_req, 0);
    chk("rwait_idle_req", mem_req, 0);
    chk("rwait_idle_wb", wb_valid, 0);
    mem_rvalid = 1'b0;
    // flush while a load stalls: the load still completes, the flushed op becomes a bubble
    drive_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0);
    flush = 1'b1;
    in_valid = 1'b1;
    mem_gnt = 1'b1;
    #1;
    nxt;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0BADF00D;
    #1;
    chk("fl_rf_we", wb_rf_we, 1);
    chk("fl_data", wb_rf_wdata, 32'h0BADF00D);
    nxt;
    mem_rvalid = 1'b0;
    #1;
    chk("fl_bubble", wb_valid, 0);
    flush = 1'b0;
    in_valid = 1'b0;
    // non-memory op: an odd address must not raise a misalign
    drive_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h77);
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_rf_we", wb_rf_we, 1);
    chk("alu_data", wb_rf_wdata, 32'h77);
    chk("alu_pc", wb_pc, 32'h1000);
    chk("alu_waddr", wb_rf_waddr, 32'd7);
    chk("alu_mis", misalign_exc, 0);
    chk("alu_stall", stall_req, 0);
    nxt;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
